// File: rtl/ladybird_csr_requester.sv
// Zicsr requester: latches one decoded CSR instruction, performs a single-cycle
// access on the CSR file port and returns the old value as the rd writeback.
module ladybird_csr_requester #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_addr,
    input  logic [4:0]      req_rs1_idx,
    input  logic [XLEN-1:0] req_rs1_data,
    input  logic [4:0]      req_rd_idx,
    output logic [2:0]      csr_op,
    output logic            csr_valid,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_data,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [4:0]      rsp_rd_idx,
    output logic [XLEN-1:0] rsp_rd_data,
    output logic            rsp_we,
    output logic            rsp_illegal,
    output logic [31:0]     illegal_count
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [11:0]     addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [4:0]      rd_idx_q, rd_idx_d;
    logic            illegal_q, illegal_d;
    logic            csr_valid_q, csr_valid_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_we_q, rsp_we_d;
    logic            rsp_illegal_q, rsp_illegal_d;
    logic [4:0]      rsp_rd_idx_q, rsp_rd_idx_d;
    logic [XLEN-1:0] rsp_rd_data_q, rsp_rd_data_d;
    logic [31:0]     illegal_count_q, illegal_count_d;

    logic req_wr, req_illegal;

    // RS/RC and their immediate forms share the rs1 field as the "nonzero" test.
    always_comb begin
        req_wr      = (req_funct3[1:0] == 2'b01) || (req_rs1_idx != 5'd0);
        req_illegal = (req_funct3[1:0] == 2'b00) || (req_wr && (req_addr[11:10] == 2'b11));
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        addr_d          = addr_q;
        data_d          = data_q;
        rd_idx_d        = rd_idx_q;
        illegal_d       = illegal_q;
        csr_valid_d     = 1'b0;
        rsp_valid_d     = rsp_valid_q;
        rsp_we_d        = rsp_we_q;
        rsp_illegal_d   = rsp_illegal_q;
        rsp_rd_idx_d    = rsp_rd_idx_q;
        rsp_rd_data_d   = rsp_rd_data_q;
        illegal_count_d = illegal_count_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d        = req_funct3;
                    addr_d      = req_addr;
                    data_d      = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_data;
                    rd_idx_d    = req_rd_idx;
                    illegal_d   = req_illegal;
                    csr_valid_d = req_wr && !req_illegal;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                // CSR file writes on this same edge, so rdata is still the old value.
                rsp_valid_d   = 1'b1;
                rsp_rd_data_d = illegal_q ? '0 : csr_rdata;
                rsp_we_d      = !illegal_q && (rd_idx_q != 5'd0);
                rsp_illegal_d = illegal_q;
                rsp_rd_idx_d  = rd_idx_q;
                state_d       = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_we_d      = 1'b0;
                    rsp_illegal_d = 1'b0;
                    if (illegal_q && (illegal_count_q != 32'hFFFF_FFFF))
                        illegal_count_d = illegal_count_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            op_q            <= '0;
            addr_q          <= '0;
            data_q          <= '0;
            rd_idx_q        <= '0;
            illegal_q       <= 1'b0;
            csr_valid_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_we_q        <= 1'b0;
            rsp_illegal_q   <= 1'b0;
            rsp_rd_idx_q    <= '0;
            rsp_rd_data_q   <= '0;
            illegal_count_q <= '0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            rd_idx_q        <= rd_idx_d;
            illegal_q       <= illegal_d;
            csr_valid_q     <= csr_valid_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_we_q        <= rsp_we_d;
            rsp_illegal_q   <= rsp_illegal_d;
            rsp_rd_idx_q    <= rsp_rd_idx_d;
            rsp_rd_data_q   <= rsp_rd_data_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign csr_op        = op_q;
    assign csr_addr      = addr_q;
    assign csr_data      = data_q;
    assign csr_valid     = csr_valid_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_we        = rsp_we_q;
    assign rsp_illegal   = rsp_illegal_q;
    assign rsp_rd_idx    = rsp_rd_idx_q;
    assign rsp_rd_data   = rsp_rd_data_q;
    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_ladybird_csr_requester.sv
// Directed bench for ladybird_csr_requester with a small behavioural CSR file.
module tb_ladybird_csr_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_rd_idx;
    logic [2:0]  csr_op;
    logic        csr_valid;
    logic [11:0] csr_addr;
    logic [31:0] csr_data;
    logic [31:0] csr_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_rd_idx;
    logic [31:0] rsp_rd_data;
    logic        rsp_we;
    logic        rsp_illegal;
    logic [31:0] illegal_count;

    int total = 0;
    int bad   = 0;

    ladybird_csr_requester #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data),
        .req_rd_idx(req_rd_idx),
        .csr_op(csr_op), .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_data(csr_data),
        .csr_rdata(csr_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_idx(rsp_rd_idx),
        .rsp_rd_data(rsp_rd_data), .rsp_we(rsp_we), .rsp_illegal(rsp_illegal),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    // CSR file model: 0x305/0x300 are writable, 0xC00 is a free-running cycle counter.
    logic [31:0] m305 = 32'h0;
    logic [31:0] m300 = 32'hFFFF_FFFF;
    logic [31:0] cyc  = 32'h0;
    int          strobes = 0;

    always_comb begin
        case (csr_addr)
            12'h305: csr_rdata = m305;
            12'h300: csr_rdata = m300;
            12'hC00: csr_rdata = cyc;
            default: csr_rdata = 32'h0;
        endcase
    end

    function automatic logic [31:0] apply_op(input logic [2:0] op, input logic [31:0] old,
                                             input logic [31:0] d);
        case (op[1:0])
            2'b01:   apply_op = d;
            2'b10:   apply_op = old | d;
            2'b11:   apply_op = old & ~d;
            default: apply_op = old;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 32'd1;
        if (csr_valid) begin
            strobes <= strobes + 1;
            if (csr_addr == 12'h305) m305 <= apply_op(csr_op, m305, csr_data);
            if (csr_addr == 12'h300) m300 <= apply_op(csr_op, m300, csr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Observations from the last transaction
    logic        a_valid;
    logic [31:0] a_data;
    logic [2:0]  a_op;
    logic [11:0] a_addr;
    logic [31:0] a_cyc;
    logic        r_valid, r_we, r_ill;
    logic [4:0]  r_rd;
    logic [31:0] r_data;

    task automatic txn(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                       input logic [31:0] d, input logic [4:0] rd, input int hold);
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_funct3 = f3; req_addr = a; req_rs1_idx = r1; req_rs1_data = d; req_rd_idx = rd;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        a_valid = csr_valid; a_data = csr_data; a_op = csr_op; a_addr = csr_addr; a_cyc = cyc;
        @(negedge clk);
        r_valid = rsp_valid; r_we = rsp_we; r_ill = rsp_illegal; r_rd = rsp_rd_idx; r_data = rsp_rd_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rsp_data", rsp_rd_data, r_data);
            chk("hold_rsp_rd", {27'b0, rsp_rd_idx}, {27'b0, r_rd});
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
            chk("hold_csr_valid", {31'b0, csr_valid}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    int s0;

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_funct3 = 3'b001; req_addr = 12'h305; req_rs1_idx = 5'd1;
        req_rs1_data = 32'hDEAD_BEEF; req_rd_idx = 5'd1;
        // Request offered during reset must not be accepted.
        req_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_csr_valid", {31'b0, csr_valid}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_we", {31'b0, rsp_we}, 32'd0);
        chk("rst_rsp_illegal", {31'b0, rsp_illegal}, 32'd0);
        chk("rst_rsp_data", rsp_rd_data, 32'd0);
        chk("rst_rsp_rd", {27'b0, rsp_rd_idx}, 32'd0);
        chk("rst_ill_cnt", illegal_count, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_csr_valid", {31'b0, csr_valid}, 32'd0);

        // CSRRW 0x305 <- 0x80000100, rd=5
        txn(3'b001, 12'h305, 5'd1, 32'h8000_0100, 5'd5, 0);
        chk("rw_strobe", {31'b0, a_valid}, 32'd1);
        chk("rw_csr_data", a_data, 32'h8000_0100);
        chk("rw_csr_op", {29'b0, a_op}, 32'd1);
        chk("rw_csr_addr", {20'b0, a_addr}, 32'h305);
        chk("rw_rsp_valid", {31'b0, r_valid}, 32'd1);
        chk("rw_rsp_rd", {27'b0, r_rd}, 32'd5);
        chk("rw_rsp_data", r_data, 32'h0);
        chk("rw_rsp_we", {31'b0, r_we}, 32'd1);
        chk("rw_rsp_ill", {31'b0, r_ill}, 32'd0);

        // CSRRS rs1=x0: pure read
        s0 = strobes;
        txn(3'b010, 12'h305, 5'd0, 32'hFFFF_FFFF, 5'd6, 0);
        chk("rs0_strobe", {31'b0, a_valid}, 32'd0);
        chk("rs0_data", r_data, 32'h8000_0100);
        chk("rs0_we", {31'b0, r_we}, 32'd1);
        chk("rs0_no_write", strobes, s0);

        // CSRRSI uimm=0 on cycle counter: legal read
        txn(3'b110, 12'hC00, 5'd0, 32'h0, 5'd7, 0);
        chk("cyc_strobe", {31'b0, a_valid}, 32'd0);
        chk("cyc_ill", {31'b0, r_ill}, 32'd0);
        chk("cyc_data", r_data, a_cyc);

        // CSRRSI uimm=3 on read-only CSR: illegal
        txn(3'b110, 12'hC00, 5'd3, 32'h0, 5'd7, 0);
        chk("ro_strobe", {31'b0, a_valid}, 32'd0);
        chk("ro_ill", {31'b0, r_ill}, 32'd1);
        chk("ro_we", {31'b0, r_we}, 32'd0);
        chk("ro_data", r_data, 32'h0);
        chk("ro_cnt", illegal_count, 32'd1);

        // CSRRCI uimm=0x1F on 0x300 (all ones)
        txn(3'b111, 12'h300, 5'h1F, 32'h0, 5'd8, 0);
        chk("rci_strobe", {31'b0, a_valid}, 32'd1);
        chk("rci_csr_data", a_data, 32'h0000_001F);
        chk("rci_csr_op", {29'b0, a_op}, 32'd7);
        chk("rci_data", r_data, 32'hFFFF_FFFF);
        txn(3'b010, 12'h300, 5'd0, 32'h0, 5'd9, 0);
        chk("rci_readback", r_data, 32'hFFFF_FFE0);

        // funct3=100 is illegal
        txn(3'b100, 12'h305, 5'd2, 32'h1, 5'd3, 0);
        chk("f100_strobe", {31'b0, a_valid}, 32'd0);
        chk("f100_ill", {31'b0, r_ill}, 32'd1);
        chk("f100_we", {31'b0, r_we}, 32'd0);
        chk("f100_cnt", illegal_count, 32'd2);

        // CSRRW with rd=x0: write still happens, no register writeback
        txn(3'b001, 12'h305, 5'd4, 32'h1234_5678, 5'd0, 0);
        chk("rd0_strobe", {31'b0, a_valid}, 32'd1);
        chk("rd0_we", {31'b0, r_we}, 32'd0);
        chk("rd0_data", r_data, 32'h8000_0100);
        txn(3'b010, 12'h305, 5'd0, 32'h0, 5'd1, 0);
        chk("rd0_readback", r_data, 32'h1234_5678);

        // Back-pressure: rsp_ready low for 10 cycles
        txn(3'b001, 12'h305, 5'd4, 32'h0000_00A5, 5'd4, 10);
        chk("bp_rsp_data", r_data, 32'h1234_5678);
        chk("bp_rsp_rd", {27'b0, r_rd}, 32'd4);
        txn(3'b010, 12'h305, 5'd0, 32'h0, 5'd2, 0);
        chk("bp_next_data", r_data, 32'h0000_00A5);

        // Reset during ACCESS
        @(negedge clk);
        req_funct3 = 3'b001; req_addr = 12'h305; req_rs1_idx = 5'd1;
        req_rs1_data = 32'h0000_00A5; req_rd_idx = 5'd2; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        s0 = strobes;
        @(negedge clk);
        chk("mr_csr_valid", {31'b0, csr_valid}, 32'd0);
        chk("mr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mr_cnt", illegal_count, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr_no_strobe", strobes, s0);
        chk("mr_rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
        txn(3'b010, 12'h305, 5'd0, 32'h0, 5'd3, 0);
        chk("mr_next_valid", {31'b0, r_valid}, 32'd1);
        chk("mr_next_data", r_data, 32'h0000_00A5);
        chk("mr_next_rd", {27'b0, r_rd}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ladybird_csr_requester.md
Name: ladybird_csr_requester

Overview:
- Initiator side of the CSR access interface; drives the CSR file's op/valid/addr/data port and collects its read data.
- Sits between the execute stage and the CSR file. It accepts one decoded Zicsr instruction per transaction over a valid/ready handshake.
- Decides whether a write side effect is required, performs the access, and returns the rd writeback (or an illegal-instruction flag) over a second valid/ready handshake.

Parameters:
- XLEN, 32, data width of rs1 operand, CSR data and rd writeback.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_funct3  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
- req_addr  in  12  CSR address.
- req_rs1_idx  in  5  rs1 field; also the uimm for the I variants.
- req_rs1_data  in  XLEN  rs1 register value.
- req_rd_idx  in  5  destination register index.
- csr_op  out  3  funct3 forwarded to the CSR file.
- csr_valid  out  1  write-enable strobe to the CSR file.
- csr_addr  out  12  CSR address.
- csr_data  out  XLEN  operand (rs1 value or zero-extended uimm).
- csr_rdata  in  XLEN  combinational read data from the CSR file for csr_addr.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rd_idx  out  5  destination register.
- rsp_rd_data  out  XLEN  old CSR value.
- rsp_we  out  1  register write required.
- rsp_illegal  out  1  illegal-instruction exception.
- illegal_count  out  32  saturating count of illegal responses.

Behaviour:
- FSM states are IDLE, ACCESS and RESP.
  - req_ready = (state == IDLE).
  - A request is accepted when req_valid & req_ready. All req_* fields are latched on acceptance.
- Operand selection:
  - funct3[2] = 1: csr_data = {XLEN-5 zeros, rs1_idx}.
  - funct3[2] = 0: csr_data = rs1_data.
- Write effect (wr):
  - RW/RWI: always.
  - RS/RC: when rs1_idx != 0.
  - RSI/RCI: when uimm != 0.
- Illegal conditions:
  - funct3 is 000 or 100.
  - wr = 1 and addr[11:10] == 2'b11 (read-only CSR).
- Transition IDLE -> ACCESS on acceptance.
- ACCESS lasts exactly 1 cycle:
  - csr_addr and csr_op driven from the latched request.
  - csr_valid = wr & ~illegal.
  - csr_rdata is captured into rsp_rd_data at the end of this cycle. The captured value is the pre-write value, because the CSR file updates on that same edge.
  - Transition to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_we = ~illegal & (rd_idx != 0).
  - rsp_illegal = illegal.
  - rsp_rd_data = 0 when illegal.
  - Hold until rsp_ready, then go to IDLE. On that handshake, if illegal, illegal_count increments unless it is 0xFFFFFFFF.
- Latency: accept at edge T, csr_valid high in cycle T+1, rsp_valid from cycle T+2. Minimum 3 cycles per transaction; throughput 1 per 3 cycles when rsp_ready is held high.
- csr_valid is high only in ACCESS, never in IDLE or RESP. Each transaction produces at most one write strobe.
- An illegal access never asserts csr_valid, but the read in ACCESS still occurs; the captured data is discarded.
- Back-pressure: RESP outputs stay stable while rsp_ready = 0. No new request is accepted until the response handshake completes.
- Outputs while idle: csr_op, csr_addr and csr_data are don't-care in IDLE, but csr_valid = 0.
- Reset (rst = 1 at an edge):
  - state = IDLE.
  - req_ready = 1 in the following cycle.
  - csr_valid, rsp_valid, rsp_we and rsp_illegal = 0.
  - rsp_rd_data, rsp_rd_idx and illegal_count = 0.
- Reset mid-transaction: an in-flight ACCESS or RESP is dropped and no csr_valid is issued after the reset edge. A reset in the same cycle as req_valid does not accept the request.

Test Plan:
- CSRRW addr 0x305, rs1_data 0x80000100, rd=5, CSR holds 0: csr_valid exactly in cycle T+1 with data 0x80000100 → response rd=5, data 0, we=1; a follow-up CSRRS rs1=x0 reads 0x80000100 with csr_valid never asserted.
- CSRRSI uimm=0 on 0xC00 (cycle), rd=7: no csr_valid, not illegal → rsp_rd_data equals the cycle counter sampled in ACCESS; CSRRSI uimm=3 on 0xC00 → rsp_illegal=1, we=0, illegal_count=1.
- CSRRCI uimm=0x1F on 0x300 holding 0xFFFFFFFF: csr_data = 0x0000001F, csr_op = 111 → response 0xFFFFFFFF; a later read returns 0xFFFFFFE0.
- funct3=100: → illegal response, no csr_valid; rd=x0 on a legal CSRRW → rsp_we = 0 with the write still performed.
- rsp_ready held low for 10 cycles: rsp_* stable and req_ready = 0 throughout → accepted on the 11th cycle, next request accepted the following cycle.
- rst asserted during ACCESS: no csr_valid after the reset edge, rsp_valid = 0, illegal_count = 0 → the next request completes normally.
